// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the clocked register file.
// The clear sequencer state enum lives here so the top and the sequencer agree on it.
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/reg_file_param_if.sv
// Bus bundle for the register file: two read ports, one write port, clear request and busy.
interface reg_file_param_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clear_req;
    logic              busy;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clear_req,
        input  rd_data1, rd_data2, busy
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clear_req,
        output rd_data1, rd_data2, busy
    );

endinterface

// File: rtl/reg_file_clear_ctrl.sv
// Clear sequencer: walks cnt over every entry after reset or a clear request.
// state | meaning
// CLEAR | writing 0 to entry cnt each cycle; user writes and reads are blocked
// IDLE  | normal operation; clear_req restarts the sweep at entry 0
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Clocked two-read/one-write register file with write-first bypass, optional zero
// register and a built-in clear sweep that blanks reads while it runs.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    reg_file_param_if.slave  bus
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              user_we;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;

    reg_file_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk       (clk),
        .reset     (reset),
        .clear_req (bus.clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // A user write is legal only in IDLE outside reset, and never to a hard-wired entry 0.
    always_comb begin
        user_we = bus.wr_en && !busy && !reset && !(ZERO_EN && (bus.wr_addr == '0));
        we_d    = 1'b0;
        waddr_d = bus.wr_addr;
        wdata_d = bus.wr_data;
        if (reset) begin
            we_d = 1'b0;
        end else if (clr_we) begin
            we_d    = 1'b1;
            waddr_d = clr_addr;
            wdata_d = '0;
        end else begin
            we_d = user_we;
        end
    end

    always_ff @(posedge clk) begin
        if (we_d) begin
            mem_q[waddr_d] <= wdata_d;
        end
    end

    assign bus.rd_data1 = busy                                        ? '0 :
                          (ZERO_EN && (bus.rd_addr1 == '0))           ? '0 :
                          (user_we && (bus.wr_addr == bus.rd_addr1))  ? bus.wr_data :
                                                                        mem_q[bus.rd_addr1];

    assign bus.rd_data2 = busy                                        ? '0 :
                          (ZERO_EN && (bus.rd_addr2 == '0))           ? '0 :
                          (user_we && (bus.wr_addr == bus.rd_addr2))  ? bus.wr_data :
                                                                        mem_q[bus.rd_addr2];

    assign bus.busy = busy;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: scoreboarded read expectations per scenario.
`timescale 1ns/1ps
module tb_reg_file_param;

    logic clk;
    logic reset;

    reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_param #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] model [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.e1 = e1;
        e.e2 = e2;
        sb_q.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        #2;
        if (sb_q.size() == 0) begin
            e.e1 = 'x;
            e.e2 = 'x;
        end else begin
            e = sb_q.pop_front();
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        reset = 1'b1;
        step();
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy: busy=%b expected 1", bus.busy);
        end
        reset = 1'b0;
        count_busy(n);
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("FAIL reset_clear_len: busy cycles=%0d expected 32", n);
        end
        for (int a = 0; a < 32; a++) begin
            bus.rd_addr1 = 5'(a);
            bus.rd_addr2 = 5'(31 - a);
            push_exp(32'h0, 32'h0);
            pop_exp(e);
            tests_run++;
            if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
                tests_failed++;
                $display("FAIL reset_zero[%0d]: rd1=%h rd2=%h expected %h %h",
                         a, bus.rd_data1, bus.rd_data2, e.e1, e.e2);
            end
            step();
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd5;
        bus.wr_data  = 32'hDEADBEEF;
        bus.rd_addr1 = 5'd5;
        bus.rd_addr2 = 5'd6;
        push_exp(32'hDEADBEEF, 32'h0);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL bypass_same: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
        bus.wr_en = 1'b0;
        push_exp(32'hDEADBEEF, 32'h0);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL bypass_next: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
    endtask

    task automatic test_zero_reg();
        exp_t e;
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 32'h12345678;
        bus.rd_addr1 = 5'd0;
        bus.rd_addr2 = 5'd0;
        push_exp(32'h0, 32'h0);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL zero_same: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
        bus.wr_en = 1'b0;
        push_exp(32'h0, 32'h0);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL zero_next: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
    endtask

    task automatic test_clear();
        exp_t e;
        int   n;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 32'hA5A5A5A5;
        step();
        bus.wr_en     = 1'b0;
        bus.clear_req = 1'b1;
        bus.rd_addr1  = 5'd7;
        bus.rd_addr2  = 5'd5;
        push_exp(32'hA5A5A5A5, 32'hDEADBEEF);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_pre: rd1=%h rd2=%h busy=%b expected %h %h busy=0",
                     bus.rd_data1, bus.rd_data2, bus.busy, e.e1, e.e2);
        end
        step();
        bus.clear_req = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = 5'd7;
        bus.wr_data   = 32'h1;
        push_exp(32'h0, 32'h0);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL clear_blank: rd1=%h rd2=%h busy=%b expected %h %h busy=1",
                     bus.rd_data1, bus.rd_data2, bus.busy, e.e1, e.e2);
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            bus.clear_req = (n == 15);
            step();
        end
        bus.wr_en     = 1'b0;
        bus.clear_req = 1'b0;
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("FAIL clear_len: busy cycles=%0d expected 32", n);
        end
        push_exp(32'h0, 32'h0);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL clear_after: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
    endtask

    task automatic test_reset_mid_clear();
        int n;
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midclr_rst_busy: busy=%b expected 1", bus.busy);
        end
        reset = 1'b0;
        count_busy(n);
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("FAIL midclr_len: busy cycles=%0d expected 32", n);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [4:0]  a1, a2, wa;
        logic [31:0] wd, x1, x2;
        logic        we;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 80; i++) begin
            a1 = 5'($urandom_range(0, 31));
            a2 = 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            wd = $urandom;
            bus.rd_addr1 = a1;
            bus.rd_addr2 = a2;
            bus.wr_en    = we;
            bus.wr_addr  = wa;
            bus.wr_data  = wd;
            x1 = (a1 == 5'd0) ? 32'h0 : (we && wa == a1) ? wd : model[a1];
            x2 = (a2 == 5'd0) ? 32'h0 : (we && wa == a2) ? wd : model[a2];
            push_exp(x1, x2);
            pop_exp(e);
            tests_run++;
            if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
                tests_failed++;
                $display("FAIL random[%0d]: rd1=%h rd2=%h expected %h %h",
                         i, bus.rd_data1, bus.rd_data2, e.e1, e.e2);
            end
            step();
            if (we && wa != 5'd0) model[wa] = wd;
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 32'h11;
        step();
        bus.wr_addr  = 5'd4;
        bus.wr_data  = 32'h22;
        bus.rd_addr1 = 5'd3;
        bus.rd_addr2 = 5'd4;
        push_exp(32'h11, 32'h22);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL b2b_bypass: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
        bus.wr_en = 1'b0;
        push_exp(32'h11, 32'h22);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL b2b_array: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd8;
        bus.wr_data  = 32'h77;
        bus.rd_addr1 = 5'd8;
        bus.rd_addr2 = 5'd8;
        push_exp(32'h77, 32'h77);
        pop_exp(e);
        tests_run++;
        if (bus.rd_data1 !== e.e1 || bus.rd_data2 !== e.e2) begin
            tests_failed++;
            $display("FAIL b2b_dual_bypass: rd1=%h rd2=%h expected %h %h",
                     bus.rd_data1, bus.rd_data2, e.e1, e.e2);
        end
        step();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        bus.rd_addr1  = '0;
        bus.rd_addr2  = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clear_req = 1'b0;
        step();
        test_reset();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
